priority_encoder_8to3: RTL and testbench

PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

---
 rtl/encoder_pkg.sv | 23 ++
 rtl/prio_enc8.sv | 36 +++
 rtl/priority_encoder_8to3.sv | 97 +++++++++
 tb/tb_priority_encoder_8to3.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared types and constants for the pending-request priority encoder.
//   N_REQ    : number of request lines
//   CODE_W   : width of the encoded index
//   state_e  : presenter FSM state (IDLE = nothing offered, PRESENT = code valid)
//   onehot() : expands an index into a one-hot request mask
// ---------------------------------------------------------------------------
package encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage : encoder_pkg

// File: rtl/prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
// Combinational 8-to-3 priority encoder.
//   LOW_FIRST : 1 = bit 0 wins, 0 = bit 7 wins
//   vec_i     : request vector to encode
//   idx_o     : index of the winning set bit (0 when vec_i is all-zero)
//   any_o     : at least one bit of vec_i is set
// ---------------------------------------------------------------------------
module prio_enc8
  import encoder_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // NOTE: every output of an always_comb block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan from the lowest-priority end so the last hit is the winner.
    if (LOW_FIRST) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end
  end

endmodule : prio_enc8

// File: rtl/priority_encoder_8to3.sv
// ---------------------------------------------------------------------------
// priority_encoder_8to3
// Collects request pulses into a pending vector and presents them one at a
// time, highest priority first, with a valid/ack handshake.
//   LOW_FIRST : 1 = bit 0 highest priority, 0 = bit 7 highest priority
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   req       : request pulses; each 1 sets the matching pending bit
//   ack       : consumer accepts the presented code (ignored when valid=0)
//   code      : index of the presented request, 0 when valid=0
//   valid     : code is meaningful; held stable until acked
//   pending   : registered pending-request vector
//   overrun   : sticky; a request hit a bit that was already pending
// ---------------------------------------------------------------------------
module priority_encoder_8to3
  import encoder_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending,
  output logic              overrun
);

  state_e              state_q;
  logic [CODE_W-1:0]   code_q;
  logic [N_REQ-1:0]    pending_q;
  logic [N_REQ-1:0]    pending_d;
  logic                overrun_q;
  logic                overrun_d;
  logic [N_REQ-1:0]    clr;
  logic [CODE_W-1:0]   nxt_idx;
  logic                nxt_any;

  assign valid   = (state_q == PRESENT);
  assign code    = code_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

  // Only a completed handshake retires the presented bit. The req OR comes
  // after the clear so a same-cycle re-request of the acked bit survives.
  always_comb begin
    clr       = (valid && ack) ? onehot(code_q) : '0;
    pending_d = (pending_q & ~clr) | req;
    overrun_d = overrun_q | (|(req & pending_q & ~clr));
  end

  // One encoder looks at the next pending vector; it serves both the first
  // load from IDLE and the back-to-back reload after an ack.
  prio_enc8 #(
    .LOW_FIRST (LOW_FIRST)
  ) u_prio_enc8 (
    .vec_i (pending_d),
    .idx_o (nxt_idx),
    .any_o (nxt_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (nxt_any) begin
            state_q <= PRESENT;
            code_q  <= nxt_idx;
          end
        end
        PRESENT: begin
          // Without ack the offered code is frozen, even if a higher
          // priority request shows up meanwhile.
          if (ack) begin
            if (nxt_any) begin
              code_q <= nxt_idx;
            end else begin
              state_q <= IDLE;
              code_q  <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule : priority_encoder_8to3

// File: tb/tb_priority_encoder_8to3.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder_8to3
// Per-cycle vector tables for a LOW_FIRST=1 and a LOW_FIRST=0 instance that
// share the same stimulus. Each vector's expected outputs (state after the
// edge) are queued when driven and popped/compared one step after the edge.
// ---------------------------------------------------------------------------
module tb_priority_encoder_8to3;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       ev;   // expected valid
    logic [2:0] ec;   // expected code
    logic [7:0] ep;   // expected pending
    logic       eo;   // expected overrun
    string      tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack;

  logic [2:0] code_a, code_b;
  logic       valid_a, valid_b;
  logic [7:0] pending_a, pending_b;
  logic       overrun_a, overrun_b;

  int checks = 0;
  int errors = 0;

  vec_t vec_a[$];
  vec_t vec_b[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  priority_encoder_8to3 #(.LOW_FIRST(1'b1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .code    (code_a),
    .valid   (valid_a),
    .pending (pending_a),
    .overrun (overrun_a)
  );

  priority_encoder_8to3 #(.LOW_FIRST(1'b0)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .code    (code_b),
    .valid   (valid_b),
    .pending (pending_b),
    .overrun (overrun_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] q, input logic a,
                              input logic ev, input logic [2:0] ec,
                              input logic [7:0] ep, input logic eo, input string tag);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a;
    v.ev = ev; v.ec = ec; v.ep = ep; v.eo = eo; v.tag = tag;
    return v;
  endfunction

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic run_vec(input vec_t v, input bit use_b);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    req = v.req;
    ack = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (use_b) begin
      check({e.tag, ".valid"},   {7'd0, valid_b},   {7'd0, e.ev});
      check({e.tag, ".code"},    {5'd0, code_b},    {5'd0, e.ec});
      check({e.tag, ".pending"}, pending_b,         e.ep);
      check({e.tag, ".overrun"}, {7'd0, overrun_b}, {7'd0, e.eo});
    end else begin
      check({e.tag, ".valid"},   {7'd0, valid_a},   {7'd0, e.ev});
      check({e.tag, ".code"},    {5'd0, code_a},    {5'd0, e.ec});
      check({e.tag, ".pending"}, pending_a,         e.ep);
      check({e.tag, ".overrun"}, {7'd0, overrun_a}, {7'd0, e.eo});
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    ack = 1'b0;

    // ---- LOW_FIRST=1 instance ------------------------------------------
    //                rst req    ack  v  code pend   ovr
    // Reset ignores req/ack, then quiet idle
    vec_a.push_back(mk(1, 8'hFF, 1, 0, 3'd0, 8'h00, 0, "rst_ignore"));
    vec_a.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00, 0, "rst_hold"));
    for (int i = 0; i < 5; i++)
      vec_a.push_back(mk(0, 8'h00, 0, 0, 3'd0, 8'h00, 0, "idle"));
    // Multi-bit burst with ack held: 2, 5, 7 back to back
    vec_a.push_back(mk(0, 8'hA4, 1, 1, 3'd2, 8'hA4, 0, "burst_c2"));
    vec_a.push_back(mk(0, 8'h00, 1, 1, 3'd5, 8'hA0, 0, "burst_c5"));
    vec_a.push_back(mk(0, 8'h00, 1, 1, 3'd7, 8'h80, 0, "burst_c7"));
    vec_a.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "burst_done"));
    vec_a.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "ack_idle"));
    // Code holds while unacked, even with a higher-priority arrival
    vec_a.push_back(mk(0, 8'h40, 0, 1, 3'd6, 8'h40, 0, "hold_c6"));
    vec_a.push_back(mk(0, 8'h00, 0, 1, 3'd6, 8'h40, 0, "hold_c6b"));
    vec_a.push_back(mk(0, 8'h02, 0, 1, 3'd6, 8'h42, 0, "hold_hi_arrive"));
    vec_a.push_back(mk(0, 8'h00, 0, 1, 3'd6, 8'h42, 0, "hold_c6c"));
    vec_a.push_back(mk(0, 8'h00, 1, 1, 3'd1, 8'h02, 0, "hold_then_c1"));
    vec_a.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "hold_done"));
    // Re-request in the ack cycle is not an overrun; unacked re-request is
    vec_a.push_back(mk(0, 8'h08, 0, 1, 3'd3, 8'h08, 0, "ovr_c3"));
    vec_a.push_back(mk(0, 8'h08, 1, 1, 3'd3, 8'h08, 0, "ack_rereq"));
    vec_a.push_back(mk(0, 8'h00, 0, 1, 3'd3, 8'h08, 0, "ovr_wait"));
    vec_a.push_back(mk(0, 8'h08, 0, 1, 3'd3, 8'h08, 1, "ovr_set"));
    vec_a.push_back(mk(0, 8'h00, 0, 1, 3'd3, 8'h08, 1, "ovr_sticky"));
    vec_a.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 1, "ovr_ack"));
    vec_a.push_back(mk(0, 8'h00, 0, 0, 3'd0, 8'h00, 1, "ovr_idle"));
    // Reset while presenting with pending=F0; req during reset dropped
    vec_a.push_back(mk(0, 8'hF0, 0, 1, 3'd4, 8'hF0, 1, "pre_rst"));
    vec_a.push_back(mk(1, 8'h0F, 1, 0, 3'd0, 8'h00, 0, "rst_present"));
    vec_a.push_back(mk(0, 8'h00, 0, 0, 3'd0, 8'h00, 0, "post_rst"));
    // First request after reset: normal one-cycle latency
    vec_a.push_back(mk(0, 8'h80, 0, 1, 3'd7, 8'h80, 0, "first_req"));
    vec_a.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "first_ack"));
    // New request arriving during a back-to-back reload
    vec_a.push_back(mk(0, 8'h11, 0, 1, 3'd0, 8'h11, 0, "b2b_c0"));
    vec_a.push_back(mk(0, 8'h02, 1, 1, 3'd1, 8'h12, 0, "b2b_c1"));
    vec_a.push_back(mk(0, 8'h00, 1, 1, 3'd4, 8'h10, 0, "b2b_c4"));
    vec_a.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "b2b_done"));

    // ---- LOW_FIRST=0 instance ------------------------------------------
    vec_b.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00, 0, "hf_rst"));
    vec_b.push_back(mk(0, 8'h81, 0, 1, 3'd7, 8'h81, 0, "hf_c7"));
    vec_b.push_back(mk(0, 8'h00, 1, 1, 3'd0, 8'h01, 0, "hf_c0"));
    vec_b.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "hf_done"));
    vec_b.push_back(mk(0, 8'h24, 1, 1, 3'd5, 8'h24, 0, "hf_c5"));
    vec_b.push_back(mk(0, 8'h00, 1, 1, 3'd2, 8'h04, 0, "hf_c2"));
    vec_b.push_back(mk(0, 8'h00, 1, 0, 3'd0, 8'h00, 0, "hf_done2"));

    for (int i = 0; i < vec_a.size(); i++) run_vec(vec_a[i], 1'b0);
    for (int i = 0; i < vec_b.size(); i++) run_vec(vec_b[i], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_priority_encoder_8to3
